// File: rtl/inst_fetch_stage_if.sv
// Bus between the IF stage and its surroundings: hazard/branch control in,
// ROM address/data, and the IF/ID pipeline register handed to decode.
interface inst_fetch_stage_if #(
    parameter int AW = 6,
    parameter int DW = 32,
    parameter int CW = 16
);
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_inst;
    logic [DW-1:0] if_inst;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] if_npc;
    logic          if_valid;
    logic [CW-1:0] fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, rom_inst,
        output rom_addr, if_inst, if_pc, if_npc, if_valid, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, rom_inst,
        input  rom_addr, if_inst, if_pc, if_npc, if_valid, fetch_count
    );
endinterface

// File: rtl/inst_fetch_stage.sv
// IF stage: owns the PC, addresses the instruction ROM and loads the IF/ID
// register, with branch redirect taking priority over hazard stall.
module inst_fetch_stage #(
    parameter int            AW       = 6,
    parameter int            DW       = 32,
    parameter int            CW       = 16,
    parameter logic [AW-1:0] RESET_PC = 6'h01,
    parameter logic [DW-1:0] NOP      = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_fetch_stage_if.master   bus
);

    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] if_inst_q, if_inst_d;
    logic [AW-1:0] if_pc_q, if_pc_d;
    logic [AW-1:0] if_npc_q, if_npc_d;
    logic          if_valid_q, if_valid_d;
    logic [CW-1:0] fetch_count_q, fetch_count_d;
    logic [AW-1:0] pc_inc;

    assign pc_inc = pc_q + AW'(1);

    // Redirect squashes IF/ID to a bubble but leaves if_pc/if_npc untouched.
    always_comb begin
        pc_d          = pc_q;
        if_inst_d     = if_inst_q;
        if_pc_d       = if_pc_q;
        if_npc_d      = if_npc_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;
        if (bus.redirect) begin
            pc_d       = bus.redirect_pc;
            if_inst_d  = NOP;
            if_valid_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d          = pc_inc;
            if_inst_d     = bus.rom_inst;
            if_pc_d       = pc_q;
            if_npc_d      = pc_inc;
            if_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_inst_q     <= NOP;
            if_pc_q       <= '0;
            if_npc_q      <= '0;
            if_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_inst_q     <= if_inst_d;
            if_pc_q       <= if_pc_d;
            if_npc_q      <= if_npc_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.if_inst     = if_inst_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_npc      = if_npc_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Scoreboard bench for inst_fetch_stage: a reference model pushes the expected
// post-edge state per cycle; each scenario task pops and compares it.
module tb_inst_fetch_stage;

    typedef struct packed {
        logic [5:0]  rom_addr;
        logic [31:0] inst;
        logic [5:0]  pc;
        logic [5:0]  npc;
        logic        valid;
        logic [15:0] count;
    } exp_t;

    logic clk;
    logic rst;
    logic [31:0] rom [64];
    exp_t sb_q[$];
    int checks;
    int failures;

    logic [5:0]  m_pc;
    logic [31:0] m_inst;
    logic [5:0]  m_ipc;
    logic [5:0]  m_npc;
    logic        m_valid;
    logic [15:0] m_cnt;

    inst_fetch_stage_if #(.AW(6), .DW(32), .CW(16)) bus ();

    inst_fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.rom_inst = rom[bus.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t observed();
        exp_t o;
        o.rom_addr = bus.rom_addr;
        o.inst     = bus.if_inst;
        o.pc       = bus.if_pc;
        o.npc      = bus.if_npc;
        o.valid    = bus.if_valid;
        o.count    = bus.fetch_count;
        return o;
    endfunction

    // Drive one cycle of control inputs, advance the model, push its expectation.
    task automatic drive_cycle(input logic r, input logic s, input logic d, input logic [5:0] t);
        exp_t e;
        @(negedge clk);
        rst             = r;
        bus.stall       = s;
        bus.redirect    = d;
        bus.redirect_pc = t;
        if (r) begin
            m_pc = 6'h01; m_inst = 32'h0; m_ipc = 6'h0; m_npc = 6'h0; m_valid = 1'b0; m_cnt = 16'h0;
        end else if (d) begin
            m_pc = t; m_inst = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_inst  = rom[m_pc];
            m_ipc   = m_pc;
            m_npc   = m_pc + 6'h01;
            m_valid = 1'b1;
            m_pc    = m_pc + 6'h01;
            m_cnt   = m_cnt + 16'h1;
        end
        e.rom_addr = m_pc; e.inst = m_inst; e.pc = m_ipc; e.npc = m_npc; e.valid = m_valid; e.count = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 6'h00);
            e = sb_q.pop_front(); o = observed(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL reset_state actual=%h required=%h", o, e);
            end
        end
        checks++;
        if (bus.rom_addr !== 6'h01 || bus.if_valid !== 1'b0 || bus.fetch_count !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_literal rom_addr=%h valid=%b count=%h required 01/0/0",
                     bus.rom_addr, bus.if_valid, bus.fetch_count);
        end
    endtask

    task automatic test_normal_fetch();
        exp_t e, o;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 6'h00);
            e = sb_q.pop_front(); o = observed(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL normal_fetch[%0d] actual=%h required=%h", i, o, e);
            end
            if (i == 0) begin
                checks++;
                if (bus.if_inst !== 32'h28033046 || bus.if_pc !== 6'h01 || bus.if_npc !== 6'h02 ||
                    bus.if_valid !== 1'b1 || bus.rom_addr !== 6'h02 || bus.fetch_count !== 16'h1) begin
                    failures++;
                    $display("[TB] FAIL first_fetch actual=%h required inst=28033046 pc=01 npc=02 v=1 addr=02 cnt=1", o);
                end
            end
        end
    endtask

    task automatic test_stall();
        exp_t e, o;
        logic [15:0] cnt_before;
        cnt_before = bus.fetch_count;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, (i < 2), 1'b0, 6'h00);
            e = sb_q.pop_front(); o = observed(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL stall[%0d] actual=%h required=%h", i, o, e);
            end
            if (i < 2) begin
                checks++;
                if (bus.rom_addr !== 6'h06 || bus.if_inst !== 32'h34000489 || bus.fetch_count !== cnt_before) begin
                    failures++;
                    $display("[TB] FAIL stall_hold addr=%h inst=%h cnt=%h required 06/34000489/%h",
                             bus.rom_addr, bus.if_inst, bus.fetch_count, cnt_before);
                end
            end
        end
        checks++;
        if (bus.if_inst !== 32'h0821a408 || bus.if_pc !== 6'h06) begin
            failures++;
            $display("[TB] FAIL stall_release inst=%h pc=%h required 0821a408/06", bus.if_inst, bus.if_pc);
        end
    endtask

    task automatic test_redirect();
        exp_t e, o;
        drive_cycle(1'b0, 1'b0, 1'b0, 6'h00);
        e = sb_q.pop_front(); o = observed(); checks++;
        if (o !== e) begin
            failures++;
            $display("[TB] FAIL redirect_pre actual=%h required=%h", o, e);
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b0, (i == 0), 6'h0A);
            e = sb_q.pop_front(); o = observed(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL redirect[%0d] actual=%h required=%h", i, o, e);
            end
            checks++;
            if (i == 0 && (bus.rom_addr !== 6'h0A || bus.if_valid !== 1'b0 || bus.if_inst !== 32'h0)) begin
                failures++;
                $display("[TB] FAIL redirect_squash addr=%h valid=%b inst=%h required 0A/0/0",
                         bus.rom_addr, bus.if_valid, bus.if_inst);
            end else if (i == 1 && (bus.if_inst !== 32'h00101464 || bus.if_pc !== 6'h0A || bus.if_valid !== 1'b1)) begin
                failures++;
                $display("[TB] FAIL redirect_target inst=%h pc=%h valid=%b required 00101464/0A/1",
                         bus.if_inst, bus.if_pc, bus.if_valid);
            end
        end
    endtask

    task automatic test_redirect_over_stall();
        exp_t e, o;
        drive_cycle(1'b0, 1'b1, 1'b1, 6'h03);
        e = sb_q.pop_front(); o = observed(); checks++;
        if (o !== e || bus.rom_addr !== 6'h03 || bus.if_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL redirect_over_stall actual=%h required=%h", o, e);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 6'h00);
        e = sb_q.pop_front(); o = observed(); checks++;
        if (o !== e) begin
            failures++;
            $display("[TB] FAIL redirect_over_stall_next actual=%h required=%h", o, e);
        end
    endtask

    task automatic test_wrap();
        exp_t e, o;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, (i == 0), 6'h3F);
            e = sb_q.pop_front(); o = observed(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL wrap[%0d] actual=%h required=%h", i, o, e);
            end
            checks++;
            if (i == 1 && (bus.if_pc !== 6'h3F || bus.if_npc !== 6'h00 || bus.rom_addr !== 6'h00)) begin
                failures++;
                $display("[TB] FAIL wrap_npc pc=%h npc=%h addr=%h required 3F/00/00", bus.if_pc, bus.if_npc, bus.rom_addr);
            end else if (i == 2 && (bus.if_pc !== 6'h00 || bus.if_valid !== 1'b1 || bus.if_inst !== 32'hDEAD0000)) begin
                failures++;
                $display("[TB] FAIL wrap_addr0 pc=%h valid=%b inst=%h required 00/1/DEAD0000", bus.if_pc, bus.if_valid, bus.if_inst);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t e, o;
        drive_cycle(1'b0, 1'b0, 1'b1, 6'h07);
        e = sb_q.pop_front(); o = observed(); checks++;
        if (o !== e) begin
            failures++;
            $display("[TB] FAIL rst_mid_stall_setup actual=%h required=%h", o, e);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle((i == 1), (i < 2), 1'b0, 6'h00);
            e = sb_q.pop_front(); o = observed(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL rst_mid_stall[%0d] actual=%h required=%h", i, o, e);
            end
            checks++;
            if (i == 1 && (bus.rom_addr !== 6'h01 || bus.if_valid !== 1'b0 || bus.fetch_count !== 16'h0)) begin
                failures++;
                $display("[TB] FAIL rst_wins addr=%h valid=%b cnt=%h required 01/0/0", bus.rom_addr, bus.if_valid, bus.fetch_count);
            end else if (i == 2 && (bus.if_pc !== 6'h01 || bus.if_inst !== 32'h28033046)) begin
                failures++;
                $display("[TB] FAIL rst_resume pc=%h inst=%h required 01/28033046", bus.if_pc, bus.if_inst);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        logic r, s, d;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 9) == 0);
            drive_cycle(r, s, d, 6'($urandom_range(0, 63)));
            e = sb_q.pop_front(); o = observed(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL random[%0d] r=%b s=%b d=%b actual=%h required=%h", i, r, s, d, o, e);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 6'h00;
        for (int i = 0; i < 64; i++) rom[i] = 32'hA5000000 | (32'(i) * 32'h00010101);
        rom[0]  = 32'hDEAD0000;
        rom[1]  = 32'h28033046;
        rom[5]  = 32'h34000489;
        rom[6]  = 32'h0821a408;
        rom[10] = 32'h00101464;

        test_reset();
        test_normal_fetch();
        test_stall();
        test_redirect();
        test_redirect_over_stall();
        test_wrap();
        test_reset_mid_stall();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
